// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer.
// Holds the fixed song ROM word layout, the rest-note code and the
// sequencer state encoding used by song_sequencer.
package song_pkg;

    // Song ROM word layout
    localparam int ROM_W    = 16;
    localparam int ADV_BIT  = 15;
    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;
    localparam int META_MSB = 2;
    localparam int META_LSB = 0;

    // A note field of zero is a rest
    localparam logic [NOTE_MSB-NOTE_LSB:0] REST_NOTE = 6'd0;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_ROM = 3'd2,
        ST_DECODE   = 3'd3,
        ST_DISPATCH = 3'd4,
        ST_WAIT_DUR = 3'd5,
        ST_DONE     = 3'd6
    } seq_state_e;

endpackage

// File: rtl/song_sequencer_beat_counter.sv
// Beat counter for the chord wait.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   clr            - synchronous clear to zero (highest priority)
//   load, load_val - load a new duration
//   dec            - decrement by one (ignored at zero)
//   zero, one      - count is 0 / count is 1
module song_sequencer_beat_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         one
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, load, or decrement (saturating at zero)
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = CNT_ZERO;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != CNT_ZERO)) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == CNT_ZERO);
    assign one  = (count_q == CNT_ONE);

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the song ROM and turns its words into timed note
// dispatches for the note-player voices.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   play               - level, 1 = run, 0 = pause
//   restart            - synchronous pulse, back to address 0 / IDLE
//   beat               - one-cycle beat strobe
//   rom_addr, rom_dout - registered ROM interface (one cycle latency)
//   note_valid/ready   - note dispatch handshake
//   note_out/dur/meta  - dispatched note fields, voice_idx = voice slot
//   chord_strobe       - pulse when a chord's wait starts
//   song_done          - pulse after the last word completes
//   overflow           - sticky, a chord had more than VOICES notes
module song_sequencer
    import song_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int NOTE_W = 6,
    parameter int VOICES = 3,
    parameter int LOOP   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play,
    input  logic              restart,
    input  logic              beat,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [ROM_W-1:0]  rom_dout,
    output logic              note_valid,
    input  logic              note_ready,
    output logic [NOTE_W-1:0] note_out,
    output logic [NOTE_W-1:0] note_dur,
    output logic [2:0]        note_meta,
    output logic [1:0]        voice_idx,
    output logic              chord_strobe,
    output logic              song_done,
    output logic              overflow
);

    localparam int VC_W = $clog2(VOICES + 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [VC_W-1:0]   VC_ZERO   = {VC_W{1'b0}};
    localparam logic [VC_W-1:0]   VC_ONE    = {{(VC_W-1){1'b0}}, 1'b1};
    localparam logic [VC_W-1:0]   VC_MAX    = VC_W'(VOICES);
    localparam logic [NOTE_W-1:0] DUR_ZERO  = {NOTE_W{1'b0}};

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] chord_start_q, chord_start_d;
    logic              scan_q, scan_d;
    logic [NOTE_W-1:0] chord_dur_q, chord_dur_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic              note_valid_q, note_valid_d;
    logic [NOTE_W-1:0] note_out_q, note_out_d;
    logic [NOTE_W-1:0] note_dur_q, note_dur_d;
    logic [2:0]        note_meta_q, note_meta_d;
    logic [1:0]        voice_idx_q, voice_idx_d;
    logic              chord_strobe_q, chord_strobe_d;
    logic              song_done_q, song_done_d;
    logic              overflow_q, overflow_d;

    // ROM word fields
    logic              w_adv_s;
    logic              w_rest_s;
    logic [NOTE_W-1:0] w_note_s;
    logic [NOTE_W-1:0] w_dur_s;
    logic [2:0]        w_meta_s;

    // Word-completion helpers: where the address goes when the current word is done
    logic              at_last_s;
    logic              stop_s;
    logic [ADDR_W-1:0] next_addr_s;
    seq_state_e        next_state_s;

    logic bc_clr_s, bc_load_s, bc_dec_s, bc_zero_s, bc_one_s;

    assign w_adv_s  = rom_dout[ADV_BIT];
    assign w_rest_s = (rom_dout[NOTE_MSB:NOTE_LSB] == REST_NOTE);
    assign w_note_s = NOTE_W'(rom_dout[NOTE_MSB:NOTE_LSB]);
    assign w_dur_s  = NOTE_W'(rom_dout[DUR_MSB:DUR_LSB]);
    assign w_meta_s = rom_dout[META_MSB:META_LSB];

    assign at_last_s    = (rom_addr_q == LAST_ADDR);
    assign stop_s       = at_last_s && (LOOP == 0);
    assign next_addr_s  = stop_s ? rom_addr_q : (rom_addr_q + ADDR_ONE);
    assign next_state_s = stop_s ? ST_DONE : ST_FETCH;

    song_sequencer_beat_counter #(
        .W (NOTE_W)
    ) u_beat_counter (
        .clk      (clk),
        .rst_n    (reset_n),
        .clr      (bc_clr_s),
        .load     (bc_load_s),
        .load_val (w_dur_s),
        .dec      (bc_dec_s),
        .zero     (bc_zero_s),
        .one      (bc_one_s)
    );

    // Next-state and next-output computation
    always_comb begin
        state_d        = state_q;
        rom_addr_d     = rom_addr_q;
        chord_start_d  = chord_start_q;
        scan_d         = scan_q;
        chord_dur_d    = chord_dur_q;
        vc_d           = vc_q;
        note_valid_d   = note_valid_q;
        note_out_d     = note_out_q;
        note_dur_d     = note_dur_q;
        note_meta_d    = note_meta_q;
        voice_idx_d    = voice_idx_q;
        chord_strobe_d = 1'b0;
        song_done_d    = 1'b0;
        overflow_d     = overflow_q;
        bc_clr_s       = 1'b0;
        bc_load_s      = 1'b0;
        bc_dec_s       = 1'b0;

        if (restart) begin
            state_d       = ST_IDLE;
            rom_addr_d    = ADDR_ZERO;
            chord_start_d = ADDR_ZERO;
            scan_d        = 1'b0;
            vc_d          = VC_ZERO;
            note_valid_d  = 1'b0;
            overflow_d    = 1'b0;
            bc_clr_s      = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (play) begin
                        state_d       = ST_FETCH;
                        scan_d        = 1'b1;
                        chord_start_d = rom_addr_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (play) begin
                        state_d = ST_WAIT_ROM;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_WAIT_ROM: begin
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (scan_q) begin
                        // Look-ahead pass: find the chord's advance word, then
                        // go back to the chord start for the dispatch pass.
                        state_d = ST_FETCH;
                        if (w_adv_s) begin
                            chord_dur_d = w_dur_s;
                            rom_addr_d  = chord_start_q;
                            scan_d      = 1'b0;
                        end else if (at_last_s) begin
                            chord_dur_d = DUR_ZERO;
                            rom_addr_d  = chord_start_q;
                            scan_d      = 1'b0;
                        end else begin
                            rom_addr_d = rom_addr_q + ADDR_ONE;
                        end
                    end else if (w_adv_s) begin
                        bc_load_s      = 1'b1;
                        vc_d           = VC_ZERO;
                        chord_strobe_d = 1'b1;
                        state_d        = ST_WAIT_DUR;
                    end else if (w_rest_s) begin
                        rom_addr_d  = next_addr_s;
                        song_done_d = at_last_s;
                        state_d     = next_state_s;
                    end else if (vc_q < VC_MAX) begin
                        note_valid_d = 1'b1;
                        note_out_d   = w_note_s;
                        note_dur_d   = chord_dur_q;
                        note_meta_d  = w_meta_s;
                        voice_idx_d  = 2'(vc_q);
                        state_d      = ST_DISPATCH;
                    end else begin
                        overflow_d  = 1'b1;
                        rom_addr_d  = next_addr_s;
                        song_done_d = at_last_s;
                        state_d     = next_state_s;
                    end
                end
                ST_DISPATCH: begin
                    // Completes regardless of play; fields stay put until accepted
                    if (note_ready) begin
                        note_valid_d = 1'b0;
                        vc_d         = vc_q + VC_ONE;
                        rom_addr_d   = next_addr_s;
                        song_done_d  = at_last_s;
                        state_d      = next_state_s;
                    end else begin
                        state_d = ST_DISPATCH;
                    end
                end
                ST_WAIT_DUR: begin
                    if (play) begin
                        bc_dec_s = beat;
                        // Leave on the beat that takes the count to zero, or at once
                        // if it was loaded with zero.
                        if (bc_zero_s || (beat && bc_one_s)) begin
                            rom_addr_d    = next_addr_s;
                            chord_start_d = next_addr_s;
                            scan_d        = !stop_s;
                            song_done_d   = at_last_s;
                            state_d       = next_state_s;
                        end else begin
                            state_d = ST_WAIT_DUR;
                        end
                    end else begin
                        state_d = ST_WAIT_DUR;
                    end
                end
                ST_DONE: begin
                    if (!play) begin
                        state_d    = ST_IDLE;
                        rom_addr_d = ADDR_ZERO;
                        vc_d       = VC_ZERO;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered-output flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            rom_addr_q     <= ADDR_ZERO;
            chord_start_q  <= ADDR_ZERO;
            scan_q         <= 1'b0;
            chord_dur_q    <= DUR_ZERO;
            vc_q           <= VC_ZERO;
            note_valid_q   <= 1'b0;
            note_out_q     <= DUR_ZERO;
            note_dur_q     <= DUR_ZERO;
            note_meta_q    <= 3'd0;
            voice_idx_q    <= 2'd0;
            chord_strobe_q <= 1'b0;
            song_done_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rom_addr_q     <= rom_addr_d;
            chord_start_q  <= chord_start_d;
            scan_q         <= scan_d;
            chord_dur_q    <= chord_dur_d;
            vc_q           <= vc_d;
            note_valid_q   <= note_valid_d;
            note_out_q     <= note_out_d;
            note_dur_q     <= note_dur_d;
            note_meta_q    <= note_meta_d;
            voice_idx_q    <= voice_idx_d;
            chord_strobe_q <= chord_strobe_d;
            song_done_q    <= song_done_d;
            overflow_q     <= overflow_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign note_valid   = note_valid_q;
    assign note_out     = note_out_q;
    assign note_dur     = note_dur_q;
    assign note_meta    = note_meta_q;
    assign voice_idx    = voice_idx_q;
    assign chord_strobe = chord_strobe_q;
    assign song_done    = song_done_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed self-checking bench for song_sequencer. Two instances share the
// stimulus: dut (LOOP=0) and dut_l (LOOP=1); each has its own registered ROM
// port reading the shared song table.
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        play = 1'b0;
    logic        restart = 1'b0;
    logic        beat = 1'b0;
    logic        note_ready = 1'b0;
    logic [15:0] rom [0:127];

    logic [6:0]  rom_addr, rom_addr_l;
    logic [15:0] rom_dout, rom_dout_l;
    logic        note_valid, note_valid_l;
    logic [5:0]  note_out, note_out_l, note_dur, note_dur_l;
    logic [2:0]  note_meta, note_meta_l;
    logic [1:0]  voice_idx, voice_idx_l;
    logic        chord_strobe, chord_strobe_l, song_done, song_done_l, overflow, overflow_l;

    int checks = 0;
    int failures = 0;

    song_sequencer #(.ADDR_W(7), .NOTE_W(6), .VOICES(3), .LOOP(0)) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .restart(restart), .beat(beat),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .note_valid(note_valid),
        .note_ready(note_ready), .note_out(note_out), .note_dur(note_dur),
        .note_meta(note_meta), .voice_idx(voice_idx), .chord_strobe(chord_strobe),
        .song_done(song_done), .overflow(overflow)
    );

    song_sequencer #(.ADDR_W(7), .NOTE_W(6), .VOICES(3), .LOOP(1)) dut_l (
        .clk(clk), .reset_n(reset_n), .play(play), .restart(restart), .beat(beat),
        .rom_addr(rom_addr_l), .rom_dout(rom_dout_l), .note_valid(note_valid_l),
        .note_ready(note_ready), .note_out(note_out_l), .note_dur(note_dur_l),
        .note_meta(note_meta_l), .voice_idx(voice_idx_l), .chord_strobe(chord_strobe_l),
        .song_done(song_done_l), .overflow(overflow_l)
    );

    always #5 clk = ~clk;

    // Registered ROMs, one read port per instance
    always @(posedge clk) begin
        rom_dout   <= rom[rom_addr];
        rom_dout_l <= rom[rom_addr_l];
    end

    function automatic logic [15:0] mk_word(input int adv, input int note, input int dur, input int meta);
        return {adv[0], note[5:0], dur[5:0], meta[2:0]};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_restart();
        @(negedge clk);
        play = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        clear_rom();
    endtask

    task automatic load_chord();
        rom[0] = mk_word(0, 27, 12, 1);
        rom[1] = mk_word(0, 30, 12, 2);
        rom[2] = mk_word(0, 35, 12, 3);
        rom[3] = mk_word(1, 35, 12, 0);
    endtask

    task automatic give_beats(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            beat = 1'b1;
            @(negedge clk);
            beat = 1'b0;
        end
    endtask

    // Bounded wait, sampled on the falling edge: 0 = note_valid, 1 = chord_strobe, 2 = song_done
    task automatic wait_for(input int sel, input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            case (sel)
                0: seen = note_valid;
                1: seen = chord_strobe;
                2: seen = song_done;
                default: seen = 1'b0;
            endcase
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({rom_addr, note_valid, note_out, note_dur, note_meta, voice_idx,
             chord_strobe, song_done, overflow} !== 30'd0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%0d valid=%0b note=%0d ovf=%0b, required all 0",
                     rom_addr, note_valid, note_out, overflow);
        end
        checks++;
        if (rom_addr_l !== 7'd0 || note_valid_l !== 1'b0) begin
            failures++;
            $display("FAIL reset_loop_outputs: got addr=%0d valid=%0b, required 0/0", rom_addr_l, note_valid_l);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_chord();
        int exp_note [3] = '{27, 30, 35};
        bit seen;
        do_restart();
        load_chord();
        note_ready = 1'b1;
        play = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_for(0, 200, seen);
            checks++;
            if (!seen) begin
                failures++;
                $display("FAIL chord_dispatch%0d: got no note_valid, required a dispatch", k);
            end else if (note_out !== 6'(exp_note[k]) || voice_idx !== 2'(k) ||
                         note_dur !== 6'd12 || note_meta !== 3'(k + 1)) begin
                failures++;
                $display("FAIL chord_dispatch%0d: got note=%0d voice=%0d dur=%0d meta=%0d, required %0d/%0d/12/%0d",
                         k, note_out, voice_idx, note_dur, note_meta, exp_note[k], k, k + 1);
            end
        end
        wait_for(1, 50, seen);
        checks++;
        if (!seen || rom_addr !== 7'd3) begin
            failures++;
            $display("FAIL chord_strobe: got seen=%0b addr=%0d, required 1/3", seen, rom_addr);
        end
        give_beats(11);
        repeat (3) @(negedge clk);
        checks++;
        if (rom_addr !== 7'd3) begin
            failures++;
            $display("FAIL chord_wait11: got addr=%0d, required 3", rom_addr);
        end
        give_beats(1);
        checks++;
        if (rom_addr !== 7'd4) begin
            failures++;
            $display("FAIL chord_wait12: got addr=%0d, required 4", rom_addr);
        end
    endtask

    task automatic test_stall();
        bit seen;
        do_restart();
        load_chord();
        note_ready = 1'b0;
        play = 1'b1;
        wait_for(0, 200, seen);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (note_valid !== 1'b1 || note_out !== 6'd27 || rom_addr !== 7'd0) begin
                failures++;
                $display("FAIL stall_hold%0d: got valid=%0b note=%0d addr=%0d, required 1/27/0",
                         c, note_valid, note_out, rom_addr);
            end
            if (c == 2) play = 1'b0;
            @(negedge clk);
        end
        note_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (note_valid !== 1'b0 || rom_addr !== 7'd1) begin
            failures++;
            $display("FAIL stall_handshake: got valid=%0b addr=%0d, required 0/1", note_valid, rom_addr);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (rom_addr !== 7'd1 || note_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_paused: got addr=%0d valid=%0b, required 1/0", rom_addr, note_valid);
        end
    endtask

    task automatic test_overflow();
        int hs = 0;
        int last_note = 0;
        bit strobe = 1'b0;
        do_restart();
        rom[0] = mk_word(0, 27, 0, 0);
        rom[1] = mk_word(0, 30, 0, 0);
        rom[2] = mk_word(0, 35, 0, 0);
        rom[3] = mk_word(0, 40, 0, 0);
        rom[4] = mk_word(1, 0, 2, 0);
        note_ready = 1'b1;
        play = 1'b1;
        for (int i = 0; i < 400 && !strobe; i++) begin
            @(negedge clk);
            if (note_valid) begin
                hs++;
                last_note = int'(note_out);
            end
            if (chord_strobe) strobe = 1'b1;
        end
        checks++;
        if (!strobe || hs != 3 || last_note != 35) begin
            failures++;
            $display("FAIL overflow_dispatch: got strobe=%0b count=%0d last=%0d, required 1/3/35", strobe, hs, last_note);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set: got %0b, required 1", overflow);
        end
        give_beats(1);
        repeat (3) @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || rom_addr !== 7'd4) begin
            failures++;
            $display("FAIL overflow_sticky: got ovf=%0b addr=%0d, required 1/4", overflow, rom_addr);
        end
        // Last beat and restart in the same cycle: restart wins
        @(negedge clk);
        beat = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        beat = 1'b0;
        restart = 1'b0;
        checks++;
        if (overflow !== 1'b0 || rom_addr !== 7'd0 || note_valid !== 1'b0) begin
            failures++;
            $display("FAIL overflow_restart: got ovf=%0b addr=%0d valid=%0b, required 0/0/0",
                     overflow, rom_addr, note_valid);
        end
    endtask

    task automatic test_pause();
        bit seen;
        do_restart();
        load_chord();
        note_ready = 1'b1;
        play = 1'b1;
        wait_for(1, 300, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL pause_strobe: got no chord_strobe, required one");
        end
        give_beats(6);
        play = 1'b0;
        give_beats(10);
        checks++;
        if (rom_addr !== 7'd3) begin
            failures++;
            $display("FAIL pause_frozen: got addr=%0d, required 3", rom_addr);
        end
        play = 1'b1;
        give_beats(5);
        repeat (2) @(negedge clk);
        checks++;
        if (rom_addr !== 7'd3) begin
            failures++;
            $display("FAIL pause_resume5: got addr=%0d, required 3", rom_addr);
        end
        // Pause in the same cycle as the last beat: that beat is ignored
        @(negedge clk);
        beat = 1'b1;
        play = 1'b0;
        @(negedge clk);
        beat = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rom_addr !== 7'd3) begin
            failures++;
            $display("FAIL pause_last_beat: got addr=%0d, required 3", rom_addr);
        end
        play = 1'b1;
        give_beats(1);
        checks++;
        if (rom_addr !== 7'd4) begin
            failures++;
            $display("FAIL pause_resume6: got addr=%0d, required 4", rom_addr);
        end
    endtask

    task automatic test_rest();
        bit strobe = 1'b0;
        bit saw_valid = 1'b0;
        do_restart();
        rom[0] = mk_word(0, 0, 8, 0);
        rom[1] = mk_word(1, 0, 24, 0);
        note_ready = 1'b1;
        play = 1'b1;
        for (int i = 0; i < 200 && !strobe; i++) begin
            @(negedge clk);
            if (note_valid) saw_valid = 1'b1;
            if (chord_strobe) strobe = 1'b1;
        end
        checks++;
        if (!strobe || saw_valid) begin
            failures++;
            $display("FAIL rest_no_dispatch: got strobe=%0b valid_seen=%0b, required 1/0", strobe, saw_valid);
        end
        give_beats(23);
        repeat (2) @(negedge clk);
        checks++;
        if (rom_addr !== 7'd1) begin
            failures++;
            $display("FAIL rest_wait23: got addr=%0d, required 1", rom_addr);
        end
        give_beats(1);
        checks++;
        if (rom_addr !== 7'd2) begin
            failures++;
            $display("FAIL rest_wait24: got addr=%0d, required 2", rom_addr);
        end
    endtask

    task automatic test_end();
        bit seen;
        int extra = 0;
        do_restart();
        play = 1'b1;
        wait_for(2, 3000, seen);
        checks++;
        if (!seen || rom_addr !== 7'd127) begin
            failures++;
            $display("FAIL end_done: got seen=%0b addr=%0d, required 1/127", seen, rom_addr);
        end
        checks++;
        if (song_done_l !== 1'b1 || rom_addr_l !== 7'd0) begin
            failures++;
            $display("FAIL end_loop_wrap: got done=%0b addr=%0d, required 1/0", song_done_l, rom_addr_l);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (song_done) extra++;
        end
        checks++;
        if (extra != 0 || rom_addr !== 7'd127) begin
            failures++;
            $display("FAIL end_hold: got extra_pulses=%0d addr=%0d, required 0/127", extra, rom_addr);
        end
        play = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_addr !== 7'd0) begin
            failures++;
            $display("FAIL end_to_idle: got addr=%0d, required 0", rom_addr);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        do_restart();
        load_chord();
        note_ready = 1'b0;
        play = 1'b1;
        wait_for(0, 200, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL areset_dispatch: got no note_valid, required a dispatch");
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rom_addr, note_valid, note_out, note_dur, note_meta, voice_idx,
             chord_strobe, song_done, overflow} !== 30'd0) begin
            failures++;
            $display("FAIL areset_outputs: got valid=%0b note=%0d dur=%0d, required all 0",
                     note_valid, note_out, note_dur);
        end
        @(negedge clk);
        reset_n = 1'b1;
        play = 1'b0;
        note_ready = 1'b1;
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_chord();
        test_stall();
        test_overflow();
        test_pause();
        test_rest();
        test_end();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
